// File: rtl/tile_map_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_map_writer_if : write/clear handshake and read port of the tile map |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface tile_map_writer_if #(
  parameter int TILE_W      = 11,
  parameter int SPRITE_BITS = 4,
  parameter int IDX_W       = 8,
  parameter int WORD_W      = 32
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [TILE_W-1:0]      wr_tile;
  logic [SPRITE_BITS-1:0] wr_sprite;
  logic                   clr_req;
  logic [SPRITE_BITS-1:0] clr_sprite;
  logic                   busy;
  logic [IDX_W-1:0]       current_tile;
  logic [WORD_W-1:0]      sprite_addr;

  modport master (
    output wr_valid, wr_tile, wr_sprite, clr_req, clr_sprite, current_tile,
    input  wr_ready, busy, sprite_addr
  );

  modport slave (
    input  wr_valid, wr_tile, wr_sprite, clr_req, clr_sprite, current_tile,
    output wr_ready, busy, sprite_addr
  );
endinterface
`default_nettype wire

// File: rtl/tile_map_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_map_writer : flop-based 256x32 tile map, nibble writes + full fill  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tile_map_writer #(
  parameter int N_REGS        = 256,
  parameter int TILES_PER_REG = 8,
  parameter int SPRITE_BITS   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  tile_map_writer_if.slave  bus
);
  localparam int IDX_W  = $clog2(N_REGS);
  localparam int SLOT_W = $clog2(TILES_PER_REG);
  localparam int WORD_W = TILES_PER_REG * SPRITE_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]             state;
  logic [0:0]             state_nxt;
  logic [IDX_W-1:0]       fill_cnt;
  logic [SPRITE_BITS-1:0] fill_sprite;
  logic                   busy_q;
  logic                   ready;
  logic                   wr_fire;
  logic                   clr_start;
  logic [WORD_W-1:0]      rd_q;
  logic [WORD_W-1:0]      map_q [N_REGS];

  logic [IDX_W-1:0]       wr_idx;
  logic [SLOT_W-1:0]      wr_slot;

  assign wr_idx    = bus.wr_tile[IDX_W+SLOT_W-1:SLOT_W];
  assign wr_slot   = bus.wr_tile[SLOT_W-1:0];
  assign clr_start = (state == S_IDLE) && bus.clr_req;
  assign wr_fire   = bus.wr_valid && ready;

  // State register, fill counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy_q      <= 1'b0;
      fill_cnt    <= '0;
      fill_sprite <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == S_CLEAR);
      if (clr_start) begin
        fill_sprite <= bus.clr_sprite;
        fill_cnt    <= '0;
      end else if (state == S_CLEAR) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.clr_req) state_nxt = S_CLEAR;
      S_CLEAR: if (fill_cnt == LAST_IDX) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // A clear request in the same cycle pre-empts any pending write
  always_comb begin
    ready = rst_n && (state == S_IDLE) && !bus.clr_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) map_q[i] <= '0;
    end else if (state == S_CLEAR) begin
      map_q[fill_cnt] <= {TILES_PER_REG{fill_sprite}};
    end else if (wr_fire) begin
      map_q[wr_idx][int'(wr_slot)*SPRITE_BITS +: SPRITE_BITS] <= bus.wr_sprite;
    end
  end

  // Read samples the pre-edge contents, so same-cycle writes show up one read later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= map_q[bus.current_tile];
  end

  assign bus.wr_ready    = ready;
  assign bus.busy        = busy_q;
  assign bus.sprite_addr = rd_q;
endmodule
`default_nettype wire

// File: tb/tb_tile_map_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tile_map_writer : directed self-checking bench for tile_map_writer    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_tile_map_writer;
  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   n;
  logic rdy_seen;

  always #5 clk = ~clk;

  tile_map_writer_if bus ();

  tile_map_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_word(input logic [7:0] idx, input logic [31:0] exp, input string tag);
    bus.current_tile = idx;
    tick();
    check(tag, bus.sprite_addr, exp);
  endtask

  task automatic write_tile(input logic [10:0] tile, input logic [3:0] spr);
    int w;
    bus.wr_valid  = 1'b1;
    bus.wr_tile   = tile;
    bus.wr_sprite = spr;
    #1;
    w = 0;
    while (!bus.wr_ready && w < 400) begin
      tick();
      w++;
    end
    check("write_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
  endtask

  // Counts samples with busy high, from the sample just after the accepting edge
  task automatic count_busy(input int repulse_at, output int cnt, output logic rdy);
    cnt = 0;
    rdy = 1'b0;
    while (bus.busy && cnt < 400) begin
      bus.clr_req = (cnt == repulse_at);
      #1;
      if (bus.wr_ready) rdy = 1'b1;
      cnt++;
      tick();
    end
    bus.clr_req = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.wr_tile      = '0;
    bus.wr_sprite    = '0;
    bus.clr_req      = 1'b0;
    bus.clr_sprite   = '0;
    bus.current_tile = '0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", bus.sprite_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 256; i++) read_word(8'(i), 32'h0, "sweep_reset");

    // Single nibble writes merging into word 2
    write_tile(11'h013, 4'hA);
    read_word(8'h02, 32'h0000_A000, "wr_013");
    write_tile(11'h017, 4'h5);
    read_word(8'h02, 32'h5000_A000, "wr_017");

    // Full fill with sprite 3
    bus.clr_req    = 1'b1;
    bus.clr_sprite = 4'h3;
    #1;
    check("clr_ready_low", 32'(bus.wr_ready), 32'd0);
    tick();
    bus.clr_req = 1'b0;
    count_busy(-1, n, rdy_seen);
    check("fill3_len", 32'(n), 32'd256);
    check("fill3_ready", 32'(rdy_seen), 32'd0);
    for (int i = 0; i < 256; i++) read_word(8'(i), 32'h3333_3333, "sweep_fill3");

    // Clear and write in the same cycle: clear wins, write lands afterwards
    bus.clr_req    = 1'b1;
    bus.clr_sprite = 4'h7;
    bus.wr_valid   = 1'b1;
    bus.wr_tile    = 11'h02A;
    bus.wr_sprite  = 4'hC;
    #1;
    check("coll_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    bus.clr_req = 1'b0;
    check("coll_busy", 32'(bus.busy), 32'd1);
    count_busy(-1, n, rdy_seen);
    check("fill7_len", 32'(n), 32'd256);
    check("fill7_ready", 32'(rdy_seen), 32'd0);
    check("coll_ready_after", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    read_word(8'h05, 32'h7777_7C77, "coll_word5");
    read_word(8'h04, 32'h7777_7777, "coll_word4");

    // Read-before-write on word 5
    bus.current_tile = 8'h05;
    bus.wr_valid     = 1'b1;
    bus.wr_tile      = 11'h028;
    bus.wr_sprite    = 4'h1;
    tick();
    bus.wr_valid = 1'b0;
    check("rbw_old", bus.sprite_addr, 32'h7777_7C77);
    tick();
    check("rbw_new", bus.sprite_addr, 32'h7777_7C71);

    // Reset at fill cycle 100
    bus.clr_req    = 1'b1;
    bus.clr_sprite = 4'h9;
    tick();
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.wr_ready), 32'd0);
    check("abort_addr", bus.sprite_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_idle", 32'(bus.wr_ready), 32'd1);
    for (int i = 0; i < 256; i++) read_word(8'(i), 32'h0, "sweep_abort");

    // Second clr_req inside CLEAR is ignored
    bus.clr_req    = 1'b1;
    bus.clr_sprite = 4'h6;
    tick();
    bus.clr_sprite = 4'hF;
    count_busy(10, n, rdy_seen);
    check("refill_len", 32'(n), 32'd256);
    read_word(8'h00, 32'h6666_6666, "refill_w0");
    read_word(8'hFF, 32'h6666_6666, "refill_w255");
    write_tile(11'h7FF, 4'h2);
    read_word(8'hFF, 32'h2666_6666, "wr_7ff");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
